// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path.
// Holds the default cache geometry, the main-memory size, the bit positions
// of the fields within a 32-bit word address, and the refill FSM state type.
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 16;
    localparam int INDEX_W    = 8;
    localparam int TAG_W      = 20;
    localparam int OFFSET_W   = 4;
    localparam int MEM_DEPTH  = 30000;

    // Word-address field positions: tag [31:12], index [11:4], offset [3:0].
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_TAG,
        ST_DONE
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller.
// Accepts a miss request, fetches the whole line one word at a time from
// main memory (one read outstanding), writes each returned word into the
// cache data array, and only then writes the tag with its valid bit so a
// partially filled line can never hit. Requests whose line lies beyond the
// end of main memory are rejected with an err pulse.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/ready  miss request handshake; req_addr is the missing word address
//   mem_rd_en        one-cycle read strobe, mem_addr is the word to read
//   mem_rd_valid     read data return, mem_rd_data is the word
//   line_wr_en       data-array write of line_wr_data at line_index/line_offset
//   tag_wr_en        tag-array write of tag_wr_data (valid set) at line_index
//   done             one-cycle pulse when the refill is complete
//   err              one-cycle pulse when a request is rejected as out of range
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int INDEX_W    = cache_pkg::INDEX_W,
    parameter int TAG_W      = cache_pkg::TAG_W,
    parameter int MEM_DEPTH  = cache_pkg::MEM_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [31:0]         req_addr,
    output logic                req_ready,
    output logic                mem_rd_en,
    output logic [31:0]         mem_addr,
    input  logic                mem_rd_valid,
    input  logic [31:0]         mem_rd_data,
    output logic                line_wr_en,
    output logic [INDEX_W-1:0]  line_index,
    output logic [3:0]          line_offset,
    output logic [31:0]         line_wr_data,
    output logic                tag_wr_en,
    output logic [TAG_W-1:0]    tag_wr_data,
    output logic                done,
    output logic                err
);

    localparam int                 TAG_LSB_L = INDEX_LSB + INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(LINE_WORDS - 1);
    localparam logic [31:0]        DEPTH_L   = 32'(MEM_DEPTH);

    refill_state_t         state_reg, state_next;
    logic [OFFSET_W-1:0]   cnt_reg, cnt_next;
    logic [TAG_W-1:0]      tag_reg, tag_next;
    logic [INDEX_W-1:0]    index_reg, index_next;
    logic                  err_reg, err_next;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_index;
    logic [31:0]           req_line_last;
    logic                  req_out_of_range;

    // The offset of the missing word is irrelevant: the whole line is fetched.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    assign req_tag   = req_addr[TAG_LSB_L +: TAG_W];
    assign req_index = req_addr[INDEX_LSB +: INDEX_W];

    // A line is refillable only if its last word exists in main memory.
    assign req_line_last    = 32'({req_tag, req_index, LAST_OFF});
    assign req_out_of_range = (req_line_last >= DEPTH_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            tag_reg   <= '0;
            index_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tag_reg   <= tag_next;
            index_reg <= index_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        tag_next     = tag_reg;
        index_next   = index_reg;
        err_next     = 1'b0;
        req_ready    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        line_wr_en   = 1'b0;
        line_wr_data = '0;
        tag_wr_en    = 1'b0;
        done         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_out_of_range) begin
                        // Rejected requests leave the latched line untouched.
                        err_next = 1'b1;
                    end else begin
                        tag_next   = req_tag;
                        index_next = req_index;
                        cnt_next   = '0;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_rd_en  = 1'b1;
                mem_addr   = 32'({tag_reg, index_reg, cnt_reg});
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Return data goes straight to the data array in the same cycle.
                if (mem_rd_valid) begin
                    line_wr_en   = 1'b1;
                    line_wr_data = mem_rd_data;
                    if (cnt_reg == LAST_OFF) begin
                        state_next = ST_TAG;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_TAG: begin
                tag_wr_en  = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign line_index  = index_reg;
    assign line_offset = 4'(cnt_reg);
    assign tag_wr_data = tag_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    localparam int MEMD = 30000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        line_wr_en;
    logic [7:0]  line_index;
    logic [3:0]  line_offset;
    logic [31:0] line_wr_data;
    logic        tag_wr_en;
    logic [19:0] tag_wr_data;
    logic        done;
    logic        err;

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .line_wr_en   (line_wr_en),
        .line_index   (line_index),
        .line_offset  (line_offset),
        .line_wr_data (line_wr_data),
        .tag_wr_en    (tag_wr_en),
        .tag_wr_data  (tag_wr_data),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int unsigned mem [0:MEMD-1];

    // memory responder
    bit          pend = 0, pend_stale = 0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;
    bit          vld_now = 0, vld_stale = 0;
    logic [31:0] vld_data = '0;
    int          lat_base = 1, stall_max = 0;

    // requester drive values applied just after each rising edge
    logic        drv_valid = 1'b0;
    logic [31:0] drv_addr  = '0;

    // behavioural model of the refill
    bit          active = 0;
    int          words_done = 0;
    int          next_rd_cyc = -1, tag_cyc = -1, done_cyc = -1, err_cyc = -1;
    logic [31:0] m_line = '0;
    logic [7:0]  m_idx = '0;
    logic [19:0] m_tag = '0;
    bit          acc_flag = 0;

    // observations used for literal checks
    int          acc_cyc = 0, done_obs = 0, rd_cnt = 0, wr_cnt = 0, tag_cnt = 0, err_cnt = 0;
    logic [31:0] first_rd = '0, last_rd = '0;
    logic [19:0] tag_obs = '0;
    logic [7:0]  idx_obs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit oob(input logic [31:0] a);
        logic [31:0] last;
        last = {a[31:4], 4'hF};
        return last >= 32'(MEMD);
    endfunction

    // one compare process: checks every cycle and advances the model
    always @(negedge clk) begin
        bit e_ready, e_rd, e_wr, e_tag, e_done, e_err, acc;
        cyc++;
        e_ready = !active;
        e_rd    = active && (cyc == next_rd_cyc);
        e_wr    = active && vld_now && !vld_stale;
        e_tag   = (cyc == tag_cyc);
        e_done  = (cyc == done_cyc);
        e_err   = (cyc == err_cyc);

        check("req_ready", req_ready, e_ready);
        check("mem_rd_en", mem_rd_en, e_rd);
        check("line_wr_en", line_wr_en, e_wr);
        check("tag_wr_en", tag_wr_en, e_tag);
        check("done", done, e_done);
        check("err", err, e_err);
        if (e_rd && mem_rd_en)
            check("mem_addr", mem_addr, m_line + 32'(words_done));
        if (e_wr && line_wr_en) begin
            check("line_offset", line_offset, 64'(words_done));
            check("line_wr_data", line_wr_data, vld_data);
        end
        if (active) begin
            check("line_index", line_index, m_idx);
            check("tag_wr_data", tag_wr_data, m_tag);
        end

        if (mem_rd_en) begin
            check("one_outstanding", 64'(pend && !pend_stale), 0);
            pend       = 1;
            pend_stale = 0;
            pend_wait  = lat_base - 1 + int'($urandom_range(0, stall_max));
            pend_addr  = mem_addr;
            if (rd_cnt == 0) first_rd = mem_addr;
            last_rd = mem_addr;
            rd_cnt++;
        end
        if (line_wr_en) wr_cnt++;
        if (tag_wr_en) begin
            tag_cnt++;
            tag_obs = tag_wr_data;
            idx_obs = line_index;
        end
        if (err) err_cnt++;
        if (done) done_obs = cyc;

        if (e_rd) next_rd_cyc = -1;
        if (e_wr) begin
            words_done++;
            if (words_done == 16) begin
                tag_cyc  = cyc + 1;
                done_cyc = cyc + 2;
            end else begin
                next_rd_cyc = cyc + 1;
            end
        end
        acc = e_ready && req_valid && !rst;
        if (e_done) begin
            active = 0;
            $display("refill done: line=0x%08h index=0x%02h tag=0x%05h", m_line, m_idx, m_tag);
        end
        if (e_err)
            $display("request rejected: out of range");
        if (acc) begin
            acc_flag = 1;
            acc_cyc  = cyc;
            if (oob(req_addr)) begin
                err_cyc = cyc + 1;
            end else begin
                active      = 1;
                words_done  = 0;
                next_rd_cyc = cyc + 1;
                m_line      = {req_addr[31:4], 4'h0};
                m_idx       = req_addr[11:4];
                m_tag       = req_addr[31:12];
            end
        end
    end

    // one clock: drive inputs just after the rising edge, return after the compare
    task automatic tick();
        @(posedge clk);
        #1;
        vld_now   = 0;
        vld_stale = 0;
        if (pend) begin
            if (pend_wait == 0) begin
                vld_now   = 1;
                vld_stale = pend_stale;
                vld_data  = (pend_addr < 32'(MEMD)) ? mem[pend_addr] : 32'hDEAD_BEEF;
                pend      = 0;
            end else begin
                pend_wait--;
            end
        end
        mem_rd_valid = vld_now;
        mem_rd_data  = vld_now ? vld_data : $urandom();
        req_valid    = drv_valid;
        req_addr     = drv_addr;
        @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] a);
        bit ok;
        ok        = 0;
        acc_flag  = 0;
        drv_valid = 1'b1;
        drv_addr  = a;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (acc_flag) begin
                ok = 1;
                break;
            end
        end
        drv_valid = 1'b0;
        check("accept_timeout", 64'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!active && !pend && !vld_now) begin
                ok = 1;
                break;
            end
        end
        tick();
        tick();
        check("idle_timeout", 64'(ok), 1);
    endtask

    task automatic clear_obs();
        rd_cnt = 0; wr_cnt = 0; tag_cnt = 0; err_cnt = 0;
        done_obs = 0; first_rd = '0; last_rd = '0;
    endtask

    task automatic check_outputs_zero(input string tagname);
        check({tagname, "_ready"}, req_ready, 1);
        check({tagname, "_zero"}, {mem_rd_en, mem_addr, line_wr_en, line_wr_data, tag_wr_en, done, err}, 0);
        check({tagname, "_fields"}, {line_index, line_offset, tag_wr_data}, 0);
    endtask

    initial begin
        bit ok;
        logic [31:0] a;
        for (int i = 0; i < MEMD; i++) mem[i] = $urandom();
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0;
        mem_rd_valid = 1'b0; mem_rd_data = 32'h1234_5678;
        #3;
        check_outputs_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reference refill with 1-cycle memory
        lat_base = 1; stall_max = 0;
        clear_obs();
        do_req(32'h0000_1234);
        wait_idle();
        check("lit_done_cycle", 64'(done_obs - acc_cyc), 34);
        check("lit_first_rd", first_rd, 32'h0000_1230);
        check("lit_last_rd", last_rd, 32'h0000_123F);
        check("lit_rd_cnt", 64'(rd_cnt), 16);
        check("lit_wr_cnt", 64'(wr_cnt), 16);
        check("lit_tag", tag_obs, 20'h00001);
        check("lit_index", idx_obs, 8'h23);

        // slow memory with random stalls
        lat_base = 3; stall_max = 2;
        clear_obs();
        do_req(32'h0000_1234);
        wait_idle();
        check("lit_slow_rd_cnt", 64'(rd_cnt), 16);
        check("lit_slow_tag_cnt", 64'(tag_cnt), 1);

        // first word beyond memory: rejected
        lat_base = 1; stall_max = 0;
        clear_obs();
        do_req(32'h0000_7530);
        wait_idle();
        check("lit_err_cnt", 64'(err_cnt), 1);
        check("lit_err_no_rd", 64'(rd_cnt), 0);
        check("lit_err_no_tag", 64'(tag_cnt), 0);

        // last line that fits entirely in memory
        clear_obs();
        do_req(32'h0000_752F);
        wait_idle();
        check("lit_edge_err", 64'(err_cnt), 0);
        check("lit_edge_index", idx_obs, 8'h52);

        // reset in the middle of a refill, with a read still outstanding
        lat_base = 3; stall_max = 0;
        clear_obs();
        do_req(32'h0000_0500);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (words_done == 5 && pend) begin
                ok = 1;
                break;
            end
        end
        check("mid_reset_reach", 64'(ok), 1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        active = 0; next_rd_cyc = -1; tag_cyc = -1; done_cyc = -1; err_cyc = -1;
        if (pend) pend_stale = 1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("lit_reset_no_tag", 64'(tag_cnt), 0);
        lat_base = 1;
        clear_obs();
        do_req(32'h0000_0040);
        wait_idle();
        check("lit_after_reset_index", idx_obs, 8'h04);
        check("lit_after_reset_wr", 64'(wr_cnt), 16);

        // new request held while busy
        clear_obs();
        do_req(32'h0000_2000);
        do_req(32'h0000_3456);
        wait_idle();
        check("lit_busy_tag_cnt", 64'(tag_cnt), 2);
        check("lit_busy_index", idx_obs, 8'h45);
        check("lit_busy_tag", tag_obs, 20'h00003);

        // randomized requests
        for (int t = 0; t < 10; t++) begin
            lat_base  = int'($urandom_range(1, 3));
            stall_max = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = $urandom();
            else a = 32'($urandom_range(0, MEMD - 1));
            do_req(a);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, words per cache line.
REQ-002 SHALL have parameter INDEX_W, default 8, line-index width (256 lines).
REQ-003 SHALL have parameter TAG_W, default 20, tag width.
REQ-004 SHALL have parameter MEM_DEPTH, default 30000, main-memory size in 32-bit words.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 req_valid  in  1  miss refill request.
REQ-009 req_addr  in  32  missing word address: tag [31:12], index [11:4], offset [3:0].
REQ-010 req_ready  out  1  high only in IDLE; request accepted when req_valid and req_ready.
REQ-011 mem_rd_en  out  1  one-cycle memory read strobe.
REQ-012 mem_addr  out  32  word address of the read.
REQ-013 mem_rd_valid  in  1  read data returned (latency >=1 cycle, one outstanding).
REQ-014 mem_rd_data  in  32  returned word.
REQ-015 line_wr_en  out  1  write one word into cache data array.
REQ-016 line_index  out  INDEX_W  line being filled.
REQ-017 line_offset  out  4  word within line.
REQ-018 line_wr_data  out  32  word to write.
REQ-019 tag_wr_en  out  1  one-cycle tag-array write with valid bit set.
REQ-020 tag_wr_data  out  TAG_W  tag to store.
REQ-021 done  out  1  one-cycle pulse, refill complete.
REQ-022 err  out  1  one-cycle pulse, request rejected as out of range.

Function
REQ-023 SHALL implement states IDLE, ISSUE, WAIT, TAG, DONE.
REQ-024 On acceptance SHALL latch req_addr tag/index, clear word counter, go ISSUE; offset bits ignored (whole line fetched, offset 0 first).
REQ-025 If {tag,index,4'hF} >= MEM_DEPTH at acceptance, SHALL pulse err next cycle, stay IDLE, issue no read, write nothing.
REQ-026 ISSUE: SHALL assert mem_rd_en for exactly one cycle with mem_addr = {tag,index,counter}, then go WAIT.
REQ-027 WAIT: on mem_rd_valid SHALL, same cycle, assert line_wr_en with line_offset=counter, line_wr_data=mem_rd_data; mem_rd_valid outside WAIT SHALL be ignored.
REQ-028 After word LINE_WORDS-1 written SHALL go TAG; otherwise increment counter (4-bit, no wrap past 15) and go ISSUE.
REQ-029 TAG: SHALL assert tag_wr_en one cycle with latched tag/index; tag written only after all 16 data words, so no partial line can hit.
REQ-030 DONE: SHALL pulse done one cycle, return IDLE; minimum refill = 2*16+2 cycles with 1-cycle memory latency.
REQ-031 req_valid while busy SHALL be ignored; requester holds req_valid until req_ready.
REQ-032 Outputs line_index, tag_wr_data SHALL remain stable from acceptance to DONE.

Reset
REQ-033 rst SHALL force IDLE immediately; req_ready=1, all other outputs 0, counter 0.
REQ-034 Reset mid-refill SHALL abort without tag_wr_en; partially written line stays invalid; a late mem_rd_valid after reset is ignored.

Structure
REQ-035 Shared package cache_pkg SHALL hold LINE_WORDS, INDEX_W, TAG_W, OFFSET_W, MEM_DEPTH, address-field slice positions and the state enumeration.
REQ-036 Single module, no sub-module; counter and FSM inline.

Verification
REQ-037 req_addr=0x0000_1234, 1-cycle memory: reads 0x1230..0x123F in order, 16 line_wr_en at index 0x23 offsets 0..15, then tag_wr_en tag 0x00001, done at cycle 34.
REQ-038 Memory latency 3 cycles, random 0-2 stall: same data written, exactly one mem_rd_en per word, never two outstanding.
REQ-039 req_addr=0x0000_7530 (word 30000): err pulse, no mem_rd_en, no tag_wr_en, req_ready stays 1.
REQ-040 rst asserted after 5th word: all outputs 0 asynchronously, no tag_wr_en; subsequent request 0x0000_0040 refills index 0x04 normally.
REQ-041 req_valid with new address during refill: ignored; accepted only after done, second refill correct.
